mem_port_arbiter: RTL

//  Shares the single byte-wide synchronous RAM port between instruction fetch (IF) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between instruction fetch and the MEM stage
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit IF_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_done_o,
    output logic [31:0]           if_inst_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [1:0]            mem_width_i,
    input  logic                  mem_sign_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_done_o,
    output logic [31:0]           mem_rdata_o,
    input  logic [7:0]            ram_din_i,
    output logic [7:0]            ram_dout_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_wr_o
);
    typedef enum logic [1:0] {IDLE, ADDR, TAIL, DONE} state_t;
    state_t state, state_nx;
    logic                  own_if, we, sgn, if_ok, go, pick_if, flush_rd;
    logic [1:0]            k, last, wid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata, word, rdata_ext;
    logic [23:0]           sh;

    assign if_ok    = if_req_i & ~if_flush_i;
    assign go       = rdy & (if_ok | mem_req_i);
    assign pick_if  = if_ok & (IF_PRIORITY | ~mem_req_i);
    assign flush_rd = own_if & if_flush_i;
    // read bytes enter from the top, so the last N bytes received sit in the upper N byte lanes
    assign word       = {ram_din_i, sh};
    assign ram_a_o    = state == ADDR ? addr + ADDR_WIDTH'(k) : '0;
    assign ram_wr_o   = state == ADDR && we;
    assign ram_dout_o = ram_wr_o ? wdata[{k, 3'b000} +: 8] : '0;
    assign if_done_o  = state == DONE && own_if;
    assign mem_done_o = state == DONE && !own_if;

    // load extension from the top-aligned assembled word
    always_comb rdata_ext = wid == 2'd0 ? {{24{sgn & word[31]}}, word[31:24]} :
                            wid == 2'd1 ? {{16{sgn & word[31]}}, word[31:16]} : word;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // next state: reads take a TAIL cycle to capture the final byte, IF reads abort on flush
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? ADDR : IDLE;
            ADDR:    state_nx = flush_rd ? IDLE : k != last ? ADDR : we ? DONE : TAIL;
            TAIL:    state_nx = flush_rd ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // request latch, byte counter, read assembly and registered read results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_if      <= 1'b0;
            we          <= 1'b0;
            sgn         <= 1'b0;
            k           <= '0;
            last        <= '0;
            wid         <= '0;
            addr        <= '0;
            wdata       <= '0;
            sh          <= '0;
            if_inst_o   <= '0;
            mem_rdata_o <= '0;
        end else begin
            if (state == IDLE && go) begin
                own_if <= pick_if;
                we     <= ~pick_if & mem_we_i;
                addr   <= pick_if ? if_addr_i : mem_addr_i;
                last   <= pick_if | mem_width_i[1] ? 2'd3 : {1'b0, mem_width_i[0]};
                wid    <= pick_if ? 2'd2 : mem_width_i;
                sgn    <= mem_sign_i;
                wdata  <= mem_wdata_i;
                k      <= '0;
            end
            if (state == ADDR) k <= k + 2'd1;
            if (state == ADDR && k != 2'd0) sh <= word[31:8];
            if (state == TAIL && !flush_rd && own_if) if_inst_o <= word;
            if (state == TAIL && !own_if) mem_rdata_o <= rdata_ext;
        end
    end
endmodule
